imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle RISC_V_Processor.
- Accepts a byte stream, typically from a UART RX, over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory starting at word 0.
- Holds the processor in reset until the image is fully loaded plus a fixed guard interval, then releases it.

Parameters:
IMEM_DEPTH, 256, instruction memory size in 32-bit words.
ADDR_W, $clog2(IMEM_DEPTH), word-address width.
RESET_HOLD, 4, cycles cpu_reset stays high after the last write.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high; returns block to initial state.
rx_data  in  8  incoming byte.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  block accepts a byte this cycle.
imem_we  out  1  instruction memory write strobe, one cycle per word.
imem_addr  out  ADDR_W  word address of the current write.
imem_wdata  out  32  word being written.
cpu_reset  out  1  drives the processor's reset; high while loading.
load_done  out  1  image loaded and processor released.
load_error  out  1  load aborted; sticky until reset.

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0; FSM=HDR_LO, byte counter=0, word counter=0.
- A byte is consumed only on a cycle with rx_valid && rx_ready. rx_ready=1 in HDR_LO, HDR_HI, DATA and CHK; 0 elsewhere.
- Frame format: count[7:0], count[15:8], then count×4 data bytes, least-significant byte first per word.
- HDR_LO: latch count low byte -> HDR_HI.
- HDR_HI: latch count high byte, then branch:
  - count==0 -> HOLD (or CHK if the feature is enabled).
  - count>IMEM_DEPTH -> ERROR.
  - otherwise -> DATA.
- DATA: 2-bit byte index selects the byte lane of an assembly register.
  - On the 4th accepted byte, the next cycle presents imem_we=1, imem_wdata=the assembled word, imem_addr=the word counter. Latency is 1 cycle from the last byte.
  - The word counter increments after the write.
  - After write number `count` -> HOLD (or CHK).
  - imem_we is never high on two consecutive cycles. At most one byte per cycle means at most one word per 4 cycles.
- rx_valid gaps: the FSM waits indefinitely; partial words are retained.
- HOLD: a down-counter loaded with RESET_HOLD. cpu_reset stays 1; at zero -> RUN.
- RUN: cpu_reset=0, load_done=1, rx_ready=0. Terminal until reset.
- ERROR: cpu_reset=1, load_error=1, rx_ready=0, imem_we=0. Terminal until reset.
- Reset mid-load: on the next edge everything returns to reset values. Words already written stay in memory; the next load overwrites them from address 0.
- imem_addr holds its last value when imem_we=0.

Optional Feature:
- Macro BOOT_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data byte (or after the header if count==0), the FSM enters CHK and accepts one byte.
  - The expected value is the XOR of all header and data bytes received.
  - Match -> HOLD; mismatch -> ERROR.
  - Words already written are not invalidated, but the processor is never released.
- When undefined: CHK state and XOR register are absent; the frame has no trailing byte.

Decomposition:
- Shared package boot_pkg holds:
  - the state enum (HDR_LO, HDR_HI, DATA, CHK, HOLD, RUN, ERROR);
  - the header byte count constant (2);
  - the bytes-per-word constant (4).
- One natural sub-module, byte_to_word_packer: shift/lane register plus 2-bit index, emitting word_valid for one cycle. The FSM and counters stay in the top module.

Test Plan:
- Load 2 words: bytes 02 00 13 05 A0 00 93 05 50 00, rx_valid continuous.
  - imem_we pulses at addr 0 with 0x00A00513 and at addr 1 with 0x00500593.
  - cpu_reset falls RESET_HOLD+1 cycles after the second write; load_done=1.
- Count 0: bytes 00 00 -> no imem_we; cpu_reset drops after RESET_HOLD cycles.
- Count over depth: header 01 01 (257 > 256) -> load_error=1, rx_ready=0, cpu_reset stays 1, no writes.
- Handshake gaps: same stimulus as the 2-word load with rx_valid low 3 cycles between each byte -> identical writes. No byte is accepted while rx_valid=0.
- Reset mid-load:
  - Assert reset after 6 data bytes -> next cycle all outputs at reset values.
  - Reload the 1-word frame 01 00 EF BE AD DE -> write 0xDEADBEEF at addr 0.
- With BOOT_LOADER_CHECKSUM_EN:
  - Frame 01 00 EF BE AD DE plus checksum 0x23 -> load_done.
  - Same frame with checksum 0x24 -> load_error=1, cpu_reset=1.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro used by this codebase: BOOT_LOADER_CHECKSUM_EN.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CHK,
    HOLD,
    RUN,
    ERROR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave; the byte source / memory side is the master.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// Little-endian byte-to-word packer: collects four bytes into lanes and
// presents the finished word with a one-cycle word_valid pulse.
module byte_to_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        last_lane,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] lanes;

    assign last_lane = (idx == LAST_LANE);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            lanes      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                idx <= idx + 1'b1;
                if (last_lane) begin
                    word       <= {byte_in, lanes};
                    word_valid <= 1'b1;
                end else begin
                    case (idx)
                        2'd0:    lanes[7:0]   <= byte_in;
                        2'd1:    lanes[15:8]  <= byte_in;
                        default: lanes[23:16] <= byte_in;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a counted little-endian image, writes it to IMEM from
// word 0, then releases cpu_reset after a guard interval. Macro: BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int RESET_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_reset,
    output logic                load_done,
    output logic                load_error
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHK;
`else
    localparam state_t AFTER_LOAD = HOLD;
`endif

    state_t            state, next_state;
    logic [7:0]        count_lo;
    logic [15:0]       count;
    logic [15:0]       hdr_count;
    logic [ADDR_W:0]   word_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              pack_valid;
    logic              pack_last;
    logic              word_done;
    logic              last_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // Gated by reset so no byte is offered as consumed while reset is held.
    assign bus.rx_ready = !reset &&
        (state == HDR_LO || state == HDR_HI || state == DATA || state == CHK);
    assign accept     = bus.rx_valid && bus.rx_ready;
    assign hdr_count  = {bus.rx_data, count_lo};
    assign pack_valid = accept && (state == DATA);
    assign word_done  = pack_valid && pack_last;
    assign last_word  = (16'(word_cnt) + 16'd1) == count;

    assign cpu_reset  = (state != RUN);
    assign load_done  = (state == RUN);
    assign load_error = (state == ERROR);

    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (bus.rx_data),
        .byte_valid (pack_valid),
        .last_lane  (pack_last),
        .word_valid (bus.imem_we),
        .word       (bus.imem_wdata)
    );

    // NOTE: next_state takes a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            HDR_LO: if (accept) next_state = HDR_HI;
            HDR_HI: begin
                if (accept) begin
                    if (hdr_count == 16'd0)                    next_state = AFTER_LOAD;
                    else if (hdr_count > 16'(IMEM_DEPTH))      next_state = ERROR;
                    else                                       next_state = DATA;
                end
            end
            // Leave on the last byte; the final write lands in the next state.
            DATA: if (word_done && last_word) next_state = AFTER_LOAD;
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK: if (accept) next_state = (bus.rx_data == csum) ? HOLD : ERROR;
`endif
            HOLD:    if (hold_cnt == '0) next_state = RUN;
            RUN:     next_state = RUN;
            ERROR:   next_state = ERROR;
            default: next_state = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HDR_LO;
            count_lo      <= '0;
            count         <= '0;
            word_cnt      <= '0;
            hold_cnt      <= HOLD_W'(RESET_HOLD);
            bus.imem_addr <= '0;
        end else begin
            state <= next_state;
            if (state == HDR_LO && accept) count_lo <= bus.rx_data;
            if (state == HDR_HI && accept) count    <= hdr_count;
            // Address is captured with the word so it holds between writes.
            if (word_done)   bus.imem_addr <= word_cnt[ADDR_W-1:0];
            if (bus.imem_we) word_cnt      <= word_cnt + 1'b1;
            if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)                        csum <= '0;
        else if (accept && state != CHK)  csum <= csum ^ bus.rx_data;
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader; honours BOOT_LOADER_CHECKSUM_EN.
module tb_imem_boot_loader;

    localparam int IMEM_DEPTH = 256;
    localparam int ADDR_W     = 8;
    localparam int RESET_HOLD = 4;

    logic clk = 1'b0;
    logic reset;
    logic cpu_reset, load_done, load_error;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled mid-cycle.
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic        prev_we   = 1'b0;
    logic        double_we = 1'b0;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(int'(bus.imem_addr));
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
            if (prev_we) double_we <= 1'b1;
        end
        prev_we <= bus.imem_we;
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             passed++;
    endtask

    logic [7:0] frame[$];
    int last_acc;
    int data_acc;

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        #1;
        while (!bus.rx_ready && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!bus.rx_ready) begin
            check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
            bus.rx_valid = 1'b0;
            @(negedge clk);
            return;
        end
        last_acc = cyc;
        @(negedge clk);
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int gap, input logic bad_csum);
        logic [7:0] x = 8'h00;
        foreach (frame[i]) begin
            send_byte(frame[i], gap);
            x ^= frame[i];
        end
        data_acc = last_acc;
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? x + 8'd1 : x, gap);
`endif
        bus.rx_valid = 1'b0;
    endtask

    task automatic restart();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},   32'(bus.rx_ready),   32'd0);
        check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),      32'd1);
        check({tag, "_load_done"},  32'(load_done),      32'd0);
        check({tag, "_load_error"}, 32'(load_error),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        #1;
        check("hdr_lo_ready", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);

        // Two-word load, continuous valid.
        restart();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        send_frame(0, 1'b0);
        #1;
        check("w2_count", 32'(wr_addr.size()), 32'd2);
        check("w2_addr0", 32'(wr_addr[0]), 32'd0);
        check("w2_data0", wr_data[0], 32'h00A00513);
        check("w2_addr1", 32'(wr_addr[1]), 32'd1);
        check("w2_data1", wr_data[1], 32'h00500593);
        check("w2_latency", 32'(wr_cyc[1]), 32'(data_acc + 1));
        repeat (RESET_HOLD) @(negedge clk);
        #1;
        check("w2_cpu_reset_held", 32'(cpu_reset), 32'd1);
        @(negedge clk); #1;
        check("w2_cpu_reset_rel", 32'(cpu_reset), 32'd0);
        check("w2_load_done", 32'(load_done), 32'd1);
        check("w2_run_ready", 32'(bus.rx_ready), 32'd0);
        check("w2_addr_hold", 32'(bus.imem_addr), 32'd1);

        // Zero-length image.
        restart();
        frame = '{8'h00, 8'h00};
        send_frame(0, 1'b0);
        #1;
        repeat (RESET_HOLD) @(negedge clk);
        #1;
        check("z_cpu_reset_held", 32'(cpu_reset), 32'd1);
        @(negedge clk); #1;
        check("z_cpu_reset_rel", 32'(cpu_reset), 32'd0);
        check("z_load_done", 32'(load_done), 32'd1);
        check("z_no_writes", 32'(wr_addr.size()), 32'd0);

        // Count beyond depth.
        restart();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        bus.rx_valid = 1'b0;
        #1;
        check("ovf_load_error", 32'(load_error), 32'd1);
        check("ovf_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (8) @(negedge clk);
        #1;
        check("ovf_cpu_reset_later", 32'(cpu_reset), 32'd1);
        check("ovf_no_writes", 32'(wr_addr.size()), 32'd0);

        // Same two-word load with 3-cycle valid gaps.
        restart();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        send_frame(3, 1'b0);
        #1;
        check("gap_count", 32'(wr_addr.size()), 32'd2);
        check("gap_addr0", 32'(wr_addr[0]), 32'd0);
        check("gap_data0", wr_data[0], 32'h00A00513);
        check("gap_addr1", 32'(wr_addr[1]), 32'd1);
        check("gap_data1", wr_data[1], 32'h00500593);
        repeat (RESET_HOLD + 2) @(negedge clk);
        #1;
        check("gap_load_done", 32'(load_done), 32'd1);

        // Reset after six data bytes, then reload a one-word image.
        restart();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05};
        foreach (frame[i]) send_byte(frame[i], 0);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;
        check_reset_values("mid");
        check("mid_partial_write", 32'(wr_addr.size()), 32'd1);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(0, 1'b0);
        #1;
        check("rl_count", 32'(wr_addr.size()), 32'd1);
        check("rl_addr0", 32'(wr_addr[0]), 32'd0);
        check("rl_data0", wr_data[0], 32'hDEADBEEF);
        repeat (RESET_HOLD + 1) @(negedge clk);
        #1;
        check("rl_load_done", 32'(load_done), 32'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Checksum mismatch: 0x24 instead of 0x23.
        restart();
        frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(0, 1'b1);
        #1;
        repeat (2) @(negedge clk);
        #1;
        check("ck_load_error", 32'(load_error), 32'd1);
        check("ck_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ck_load_done", 32'(load_done), 32'd0);
        check("ck_word_kept", wr_data[0], 32'hDEADBEEF);
`endif

        check("no_back_to_back_we", 32'(double_we), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
